// File: rtl/apb_pkg.sv
// Shared types and defaults for the single-outstanding APB3 requester.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32'd32;
  localparam int unsigned APB_DATA_W = 32'd32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting for pready and flags when the limit is hit.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 32'd16
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 32'd1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority, counting sticks at the top instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero limit means the requester waits forever
  assign expired_o = (TIMEOUT != 32'd0) && (cnt_q == LIMIT);

endmodule

// File: rtl/apb_master.sv
// APB3 requester: one command in flight, SETUP/ACCESS sequencing, pready timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 32'd16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req_ready_q, psel_q, penable_q, rsp_valid_q;
  logic              timer_clr_s, timer_en_s, expired_s;

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .pclk     (pclk),
    .presetn  (presetn),
    .clr_i    (timer_clr_s),
    .en_i     (timer_en_s),
    .expired_o(expired_s)
  );

  // Transfer sequencing; APB inputs only matter while in ACCESS
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    timer_clr_s = 1'b0;
    timer_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d     = SETUP;
          paddr_d     = req_addr_i;
          pwrite_d    = req_write_i;
          pwdata_d    = req_wdata_i;
          timer_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          state_d = RESP;
          rdata_d = pwrite_q ? {DATA_W{1'b0}} : prdata_i;
          err_d   = pslverr_i;
        end else if (expired_s) begin
          state_d = RESP;
          rdata_d = {DATA_W{1'b0}};
          err_d   = 1'b1;
        end else begin
          state_d    = ACCESS;
          timer_en_s = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake/select flags are registered from next state so no input reaches an output
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      paddr_q     <= {ADDR_W{1'b0}};
      pwrite_q    <= 1'b0;
      pwdata_q    <= {DATA_W{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_ready_q <= (state_d == IDLE);
      psel_q      <= (state_d == SETUP) || (state_d == ACCESS);
      penable_q   <= (state_d == ACCESS);
      rsp_valid_q <= (state_d == RESP);
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign paddr_o     = paddr_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;

endmodule
